// File: rtl/my_bus_if.sv
// rtl/my_bus_if.sv - enable/data bus bundle between driver (master) and counting endpoint (slave)
// MY_BUS_MONITOR_EN adds the en_cycles/bursts monitor signals.
interface my_bus_if #(
   parameter int DATA_W = 8
);
   logic              enable;
   logic [DATA_W-1:0] data;
   logic              wrap;
   logic              active;
`ifdef MY_BUS_MONITOR_EN
   logic [15:0]       en_cycles;
   logic [15:0]       bursts;
`endif

   modport master (
      output enable,
      input  data,
      input  wrap,
`ifdef MY_BUS_MONITOR_EN
      input  en_cycles,
      input  bursts,
`endif
      input  active
   );

   modport slave (
      input  enable,
      output data,
      output wrap,
`ifdef MY_BUS_MONITOR_EN
      output en_cycles,
      output bursts,
`endif
      output active
   );
endinterface

// File: rtl/my_bus.sv
// rtl/my_bus.sv - registered up-counter on a data/enable bus, clears when enable drops
// MY_BUS_MONITOR_EN adds saturating enabled-cycle and burst counters.
module my_bus #(
   parameter int DATA_W   = 8,
   parameter int SATURATE = 0,
   parameter int INC_STEP = 1
) (
   input  logic     clk,
   input  logic     rst,
   my_bus_if.slave  bus
);
   localparam logic [DATA_W:0]   STEP = (DATA_W + 1)'(INC_STEP);
   localparam logic [DATA_W-1:0] ONES = '1;

   logic [DATA_W-1:0] data_q, data_d;
   logic              wrap_q, wrap_d;
   logic              active_q;
   logic [DATA_W:0]   sum;
   logic              en;

   assign en = bus.enable;

   always_comb begin
      sum    = {1'b0, data_q} + STEP;
      data_d = '0;
      wrap_d = 1'b0;
      if (en) begin
         if (SATURATE != 0) begin
            data_d = sum[DATA_W] ? ONES : sum[DATA_W-1:0];
            // pulse only on the edge that first lands on all-ones
            wrap_d = (data_d == ONES) && (data_q != ONES);
         end else begin
            data_d = sum[DATA_W-1:0];
            wrap_d = sum[DATA_W];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q   <= '0;
         wrap_q   <= 1'b0;
         active_q <= 1'b0;
      end else begin
         data_q   <= data_d;
         wrap_q   <= wrap_d;
         active_q <= en;
      end
   end

   assign bus.data   = data_q;
   assign bus.wrap   = wrap_q;
   assign bus.active = active_q;

`ifdef MY_BUS_MONITOR_EN
   logic [15:0] en_cycles_q, en_cycles_d;
   logic [15:0] bursts_q, bursts_d;

   always_comb begin
      en_cycles_d = en_cycles_q;
      bursts_d    = bursts_q;
      if (en && (en_cycles_q != 16'hFFFF)) begin
         en_cycles_d = en_cycles_q + 16'd1;
      end
      // a burst starts when enable is seen high after a low edge
      if (en && !active_q && (bursts_q != 16'hFFFF)) begin
         bursts_d = bursts_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_cycles_q <= '0;
         bursts_q    <= '0;
      end else begin
         en_cycles_q <= en_cycles_d;
         bursts_q    <= bursts_d;
      end
   end

   assign bus.en_cycles = en_cycles_q;
   assign bus.bursts    = bursts_q;
`endif
endmodule

// File: tb/tb_my_bus.sv
// tb/tb_my_bus.sv - scoreboard bench for my_bus, 8-bit wrapping and 4-bit saturating instances
module tb_my_bus;
   logic clk;
   logic rst;

   my_bus_if #(.DATA_W(8)) bus8 ();
   my_bus_if #(.DATA_W(4)) bus4 ();

   my_bus #(.DATA_W(8), .SATURATE(0), .INC_STEP(1)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8.slave)
   );

   my_bus #(.DATA_W(4), .SATURATE(1), .INC_STEP(1)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4.slave)
   );

   typedef struct {
      logic [7:0]  d8;
      logic        w8;
      logic [3:0]  d4;
      logic        w4;
      logic        act;
`ifdef MY_BUS_MONITOR_EN
      logic [15:0] ec;
      logic [15:0] bu;
`endif
   } exp_t;

   exp_t exp_q[$];

   int n_vec;
   int n_err;
   int m8, m4, mec, mbu;
   bit mact;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m8   = 0;
      m4   = 0;
      mec  = 0;
      mbu  = 0;
      mact = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " d8"},  32'(bus8.data),   32'd0);
      chk({tag, " w8"},  32'(bus8.wrap),   32'd0);
      chk({tag, " a8"},  32'(bus8.active), 32'd0);
      chk({tag, " d4"},  32'(bus4.data),   32'd0);
      chk({tag, " w4"},  32'(bus4.wrap),   32'd0);
      chk({tag, " a4"},  32'(bus4.active), 32'd0);
   endtask

   task automatic step(input bit en);
      exp_t e;
      exp_t got;
      e.w8 = en && (m8 == 255);
      m8   = en ? (m8 + 1) % 256 : 0;
      e.w4 = en && (m4 == 14);
      m4   = en ? ((m4 < 15) ? m4 + 1 : 15) : 0;
      e.d8 = 8'(m8);
      e.d4 = 4'(m4);
      e.act = en;
`ifdef MY_BUS_MONITOR_EN
      if (en && mec < 65535) mec++;
      if (en && !mact && mbu < 65535) mbu++;
      e.ec = 16'(mec);
      e.bu = 16'(mbu);
`endif
      mact = en;
      exp_q.push_back(e);
      bus8.enable = en;
      bus4.enable = en;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         chk("scoreboard empty", 32'd0, 32'd1);
      end else begin
         got = exp_q.pop_front();
         chk("data8",  32'(bus8.data),   32'(got.d8));
         chk("wrap8",  32'(bus8.wrap),   32'(got.w8));
         chk("act8",   32'(bus8.active), 32'(got.act));
         chk("data4",  32'(bus4.data),   32'(got.d4));
         chk("wrap4",  32'(bus4.wrap),   32'(got.w4));
         chk("act4",   32'(bus4.active), 32'(got.act));
`ifdef MY_BUS_MONITOR_EN
         chk("en_cycles8", 32'(bus8.en_cycles), 32'(got.ec));
         chk("bursts8",    32'(bus8.bursts),    32'(got.bu));
         chk("en_cycles4", 32'(bus4.en_cycles), 32'(got.ec));
         chk("bursts4",    32'(bus4.bursts),    32'(got.bu));
`endif
      end
   endtask

   initial begin
      bit pat [8];
      n_vec = 0;
      n_err = 0;
      model_reset();
      rst = 1'b0;
      bus8.enable = 1'b1;
      bus4.enable = 1'b1;
      #1 rst = 1'b1;
      #1 chk_zero("rst t0");
      repeat (2) begin
         @(posedge clk);
         #1 chk_zero("rst held");
      end
      rst = 1'b0;
      model_reset();

      // count 1,2,3 then clear; first edge after release gives 1
      step(1'b1);
      step(1'b1);
      step(1'b1);
      step(1'b0);

      for (int i = 0; i < 6; i++) step(i % 2 == 0);

      // full wrap of the 8-bit counter and saturation of the 4-bit one
      for (int i = 0; i < 256; i++) step(1'b1);
      step(1'b1);
      step(1'b0);

      for (int i = 0; i < 5; i++) step(1'b1);
      chk("pre-async d8", 32'(bus8.data), 32'd5);
      #3 rst = 1'b1;
      #1 chk_zero("async rst");
      @(posedge clk);
      #1 chk_zero("async held");
      rst = 1'b0;
      model_reset();

      pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 8; i++) step(pat[i]);
`ifdef MY_BUS_MONITOR_EN
      chk("final en_cycles", 32'(bus8.en_cycles), 32'd6);
      chk("final bursts",    32'(bus8.bursts),    32'd3);
`endif
      chk("final d8", 32'(bus8.data), 32'd3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
